// File: rtl/instr_fetch_if.sv
// Control-word fetch bus: ROM read port on one side, valid/ready word handoff to the control unit on the other.
// The master modport is the fetch unit; the slave modport is the ROM plus control unit pair.
interface instr_fetch_if #(
   parameter int ROM_AW = 16
);
   logic              fetchEn;
   logic [15:0]       romAdd;
   logic [ROM_AW-1:0] romAddr;
   logic              romRead;
   logic [15:0]       romData;
   logic [31:0]       controlWord;
   logic              wordValid;
   logic              ready;
   logic [15:0]       reqAdd;

   modport master (
      input  fetchEn, romAdd, romData, ready,
      output romAddr, romRead, controlWord, wordValid, reqAdd
   );

   modport slave (
      output fetchEn, romAdd, romData, ready,
      input  romAddr, romRead, controlWord, wordValid, reqAdd
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: builds each 32-bit control word from two 16-bit ROM halves and hands it over with valid/ready.
// Optional `FETCH_COUNT_EN adds a 16-bit count of completed handshakes on port fetchCount.
module instr_fetch #(
   parameter logic [15:0] ROM_BASE = 16'h0000,
   parameter int          ROM_AW   = 16
) (
   input  logic         CLK,
   input  logic         RST,
`ifdef FETCH_COUNT_EN
   output logic [15:0]  fetchCount,
`endif
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, VALID} fetchStateT;

   fetchStateT        state, stateNext;
   logic [ROM_AW-1:0] romAddrQ, romAddrNext;
   logic              romReadQ, romReadNext;
   logic [31:0]       wordQ, wordNext;
   logic              validQ, validNext;
   logic [15:0]       reqQ, reqNext;
   logic [15:0]       loNew, hiCur;
   logic              redirect, restart;

   // Both halves are computed mod 2^16 and then cut down to the ROM address width.
   assign loNew    = ROM_BASE + {bus.romAdd[14:0], 1'b0};
   assign hiCur    = ROM_BASE + {reqQ[14:0], 1'b0} + 16'd1;
   assign redirect = (bus.romAdd != reqQ);

   assign bus.romAddr     = romAddrQ;
   assign bus.romRead     = romReadQ;
   assign bus.controlWord = wordQ;
   assign bus.wordValid   = validQ;
   assign bus.reqAdd      = reqQ;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         romAddrQ <= '0;
         romReadQ <= 1'b0;
         wordQ    <= '0;
         validQ   <= 1'b0;
         reqQ     <= '0;
      end else begin
         state    <= stateNext;
         romAddrQ <= romAddrNext;
         romReadQ <= romReadNext;
         wordQ    <= wordNext;
         validQ   <= validNext;
         reqQ     <= reqNext;
      end
   end

   // A handshake in VALID takes priority over a redirect; any restart re-latches romAdd and reissues the low half.
   always_comb begin
      stateNext   = state;
      romAddrNext = romAddrQ;
      romReadNext = romReadQ;
      wordNext    = wordQ;
      validNext   = validQ;
      reqNext     = reqQ;
      restart     = 1'b0;

      case (state)
         IDLE: begin
            romReadNext = 1'b0;
            if (bus.fetchEn) restart = 1'b1;
         end
         WAIT_LO: begin
            if (redirect) begin
               restart = 1'b1;
            end else begin
               wordNext[15:0] = bus.romData;
               romAddrNext    = hiCur[ROM_AW-1:0];
               romReadNext    = 1'b1;
               stateNext      = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (redirect) begin
               restart = 1'b1;
            end else begin
               wordNext[31:16] = bus.romData;
               romReadNext     = 1'b0;
               validNext       = 1'b1;
               stateNext       = VALID;
            end
         end
         VALID: begin
            if (bus.ready) begin
               validNext = 1'b0;
               if (bus.fetchEn) begin
                  restart = 1'b1;
               end else begin
                  romReadNext = 1'b0;
                  stateNext   = IDLE;
               end
            end else if (redirect) begin
               validNext = 1'b0;
               restart   = 1'b1;
            end
         end
         default: begin
            romReadNext = 1'b0;
            validNext   = 1'b0;
            stateNext   = IDLE;
         end
      endcase

      if (restart) begin
         reqNext     = bus.romAdd;
         romAddrNext = loNew[ROM_AW-1:0];
         romReadNext = 1'b1;
         stateNext   = WAIT_LO;
      end
   end

`ifdef FETCH_COUNT_EN
   // Only accepted words count, so fetches thrown away by a redirect never show up here.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) fetchCount <= '0;
      else if (validQ && bus.ready) fetchCount <= fetchCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboarded control words, hold/redirect/wrap/reset scenarios.
// A second instance with ROM_BASE=16'h0100 exercises address wrap-around.
module tb_instr_fetch;

   typedef struct {
      logic [31:0] word;
      logic [15:0] idx;
   } expT;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   hsCount = 0;
   expT  expQ[$];

   always #5 CLK = ~CLK;

   instr_fetch_if busA ();
   instr_fetch_if busB ();

`ifdef FETCH_COUNT_EN
   logic [15:0] fetchCountA;
   logic [15:0] fetchCountB;
`endif

   instr_fetch #(.ROM_BASE(16'h0000), .ROM_AW(16)) dutA (
      .CLK        (CLK),
      .RST        (RST),
`ifdef FETCH_COUNT_EN
      .fetchCount (fetchCountA),
`endif
      .bus        (busA.master)
   );

   instr_fetch #(.ROM_BASE(16'h0100), .ROM_AW(16)) dutB (
      .CLK        (CLK),
      .RST        (RST),
`ifdef FETCH_COUNT_EN
      .fetchCount (fetchCountB),
`endif
      .bus        (busB.master)
   );

   // ROM contents: two fixed words at the bottom, an address-derived pattern elsewhere.
   function automatic logic [15:0] romModel(input logic [15:0] a);
      if (a == 16'h0000) return 16'h0018;
      if (a == 16'h0001) return 16'h1234;
      return a ^ 16'h5A5A;
   endfunction

   function automatic logic [31:0] expWord(input logic [15:0] base, input logic [15:0] idx);
      logic [15:0] lo;
      lo = base + {idx[14:0], 1'b0};
      return {romModel(lo + 16'd1), romModel(lo)};
   endfunction

   assign busA.romData = romModel(busA.romAddr);
   assign busB.romData = romModel(busB.romAddr);

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] add, input logic rdy);
      busA.fetchEn = en;
      busA.romAdd  = add;
      busA.ready   = rdy;
   endtask

   task automatic expectFetch(input logic [15:0] idx);
      expT e;
      e.word = expWord(16'h0000, idx);
      e.idx  = idx;
      expQ.push_back(e);
   endtask

   // Called when wordValid and ready are both high, i.e. the handshake completes at the next edge.
   task automatic scoreWord(input string tag);
      expT e;
      checkOutput({tag, "_queued"}, {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput({tag, "_word"}, busA.controlWord, e.word);
         checkOutput({tag, "_reqAdd"}, {16'd0, busA.reqAdd}, {16'd0, e.idx});
         hsCount++;
      end
   endtask

   task automatic waitValid(input string tag, input int budget);
      for (int i = 0; i < budget && busA.wordValid !== 1'b1; i++) tick();
      checkOutput({tag, "_waitValid"}, {31'd0, busA.wordValid}, 32'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_romAddr"}, {16'd0, busA.romAddr}, 32'd0);
      checkOutput({tag, "_romRead"}, {31'd0, busA.romRead}, 32'd0);
      checkOutput({tag, "_word"}, busA.controlWord, 32'd0);
      checkOutput({tag, "_valid"}, {31'd0, busA.wordValid}, 32'd0);
      checkOutput({tag, "_reqAdd"}, {16'd0, busA.reqAdd}, 32'd0);
`ifdef FETCH_COUNT_EN
      checkOutput({tag, "_count"}, {16'd0, fetchCountA}, 32'd0);
`endif
   endtask

   initial begin
      applyStimulus(1'b0, 16'h0000, 1'b0);
      busB.fetchEn = 1'b0;
      busB.romAdd  = 16'h0000;
      busB.ready   = 1'b1;

      // Reset state
      tick();
      tick();
      checkAllZero("reset");
      RST = 1'b0;
      tick();

      // Basic fetch of index 0 with ready held high: 3-cycle latency
      applyStimulus(1'b1, 16'h0000, 1'b1);
      expectFetch(16'h0000);
      tick();
      checkOutput("t1_lo_addr", {16'd0, busA.romAddr}, 32'h0);
      checkOutput("t1_lo_read", {31'd0, busA.romRead}, 32'd1);
      tick();
      checkOutput("t1_hi_addr", {16'd0, busA.romAddr}, 32'h1);
      checkOutput("t1_hi_valid", {31'd0, busA.wordValid}, 32'd0);
      tick();
      checkOutput("t1_valid", {31'd0, busA.wordValid}, 32'd1);
      checkOutput("t1_read_off", {31'd0, busA.romRead}, 32'd0);
      checkOutput("t1_literal", busA.controlWord, 32'h12340018);
      scoreWord("t1");
      busA.fetchEn = 1'b0;
      tick();
      checkOutput("t1_drop", {31'd0, busA.wordValid}, 32'd0);
      checkOutput("t1_idle_read", {31'd0, busA.romRead}, 32'd0);

      // Backpressure: word held for 5 cycles, then handshake and next fetch of index 1
      applyStimulus(1'b1, 16'h0000, 1'b0);
      expectFetch(16'h0000);
      waitValid("t2", 8);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t2_hold_valid", {31'd0, busA.wordValid}, 32'd1);
         checkOutput("t2_hold_word", busA.controlWord, 32'h12340018);
         checkOutput("t2_hold_req", {16'd0, busA.reqAdd}, 32'd0);
      end
      applyStimulus(1'b1, 16'h0001, 1'b1);
      scoreWord("t2");
      expectFetch(16'h0001);
      tick();
      checkOutput("t2_after_hs_valid", {31'd0, busA.wordValid}, 32'd0);
      checkOutput("t2_next_addr", {16'd0, busA.romAddr}, 32'd2);
      checkOutput("t2_next_read", {31'd0, busA.romRead}, 32'd1);
      waitValid("t2b", 8);
      scoreWord("t2b");
      busA.fetchEn = 1'b0;
      tick();

      // Redirect 4 -> 9 while in WAIT_HI: word for 4 must never appear
      applyStimulus(1'b1, 16'h0004, 1'b0);
      tick();
      checkOutput("t3_lo4", {16'd0, busA.romAddr}, 32'd8);
      tick();
      checkOutput("t3_hi4", {16'd0, busA.romAddr}, 32'd9);
      busA.romAdd = 16'h0009;
      tick();
      checkOutput("t3_reissue", {16'd0, busA.romAddr}, 32'd18);
      checkOutput("t3_no_valid", {31'd0, busA.wordValid}, 32'd0);
      expectFetch(16'h0009);
      waitValid("t3", 8);
      busA.ready = 1'b1;
      scoreWord("t3");
      busA.fetchEn = 1'b0;
      tick();
      checkOutput("t3_drop", {31'd0, busA.wordValid}, 32'd0);
`ifdef FETCH_COUNT_EN
      checkOutput("t3_fetchCount", {16'd0, fetchCountA}, hsCount);
`endif

      // Address wrap with ROM_BASE=16'h0100 and romAdd=16'hFFFF
      busB.romAdd  = 16'hFFFF;
      busB.fetchEn = 1'b1;
      tick();
      busB.fetchEn = 1'b0;
      checkOutput("t4_lo_wrap", {16'd0, busB.romAddr}, 32'h00FE);
      tick();
      checkOutput("t4_hi_wrap", {16'd0, busB.romAddr}, 32'h00FF);
      tick();
      checkOutput("t4_valid", {31'd0, busB.wordValid}, 32'd1);
      checkOutput("t4_word", busB.controlWord, expWord(16'h0100, 16'hFFFF));
      tick();

      // Reset asserted in WAIT_LO takes effect without waiting for a clock edge
      applyStimulus(1'b1, 16'h0005, 1'b0);
      tick();
      checkOutput("t5_in_fetch", {31'd0, busA.romRead}, 32'd1);
      RST = 1'b1;
      #1;
      checkAllZero("t5_async");
      #1;
      RST = 1'b0;
      expectFetch(16'h0005);
      tick();
      checkOutput("t5_restart_addr", {16'd0, busA.romAddr}, 32'd10);
      waitValid("t5", 8);
      busA.ready = 1'b1;
      scoreWord("t5");
      busA.fetchEn = 1'b0;
      tick();
`ifdef FETCH_COUNT_EN
      checkOutput("t5_fetchCount", {16'd0, fetchCountA}, 32'd1);
`endif
      checkOutput("end_queue_empty", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
